// File: rtl/shift_sched_pkg.sv
// Shared definitions for the shift scheduler: FSM state encoding and
// default operand / shift-width sizes.
package shift_sched_pkg;

  localparam int STATE_W    = 2;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_SW_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step_unit.sv
// Datapath of the shared shifter: an accumulator that shifts left by one
// bit per step with zero fill, and a down-counter of remaining steps.
module shift_step_unit
  import shift_sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SW_W   = DEF_SW_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] load_val,
  input  logic [SW_W-1:0]   load_cnt,
  output logic [DATA_W-1:0] acc_shift,
  output logic              last_step
);

  logic [DATA_W-1:0] acc_r;
  logic [SW_W-1:0]   cnt_r;

  // Next accumulator value for one step; MSB is discarded, LSB zero filled.
  assign acc_shift = {acc_r[DATA_W-2:0], 1'b0};
  // The step taken while the counter reads one is the final one.
  assign last_step = (cnt_r == SW_W'(1));

  // Accumulator / counter: load captures a new operation, step advances it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_r <= {DATA_W{1'b0}};
      cnt_r <= {SW_W{1'b0}};
    end else if (load) begin
      acc_r <= load_val;
      cnt_r <= load_cnt;
    end else if (step) begin
      acc_r <= acc_shift;
      cnt_r <= cnt_r - SW_W'(1);
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/shift_scheduler.sv
// Two-requester scheduler for one bit-serial left shifter. A round-robin
// arbiter picks the requester, the FSM walks IDLE -> SHIFT -> DONE and the
// result plus a one-cycle done pulse are presented from registers.
module shift_scheduler
  import shift_sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SW_W   = DEF_SW_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic [DATA_W-1:0] a0,
  input  logic [SW_W-1:0]   sw0,
  input  logic              req1,
  input  logic [DATA_W-1:0] a1,
  input  logic [SW_W-1:0]   sw1,
  output logic              busy,
  output logic              grant_id,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] result
);

  state_t            state_r;
  state_t            state_next_s;
  logic              last_r;
  logic              grant_id_r;
  logic              busy_r;
  logic              done0_r;
  logic              done1_r;
  logic [DATA_W-1:0] result_r;

  logic              arb_win_s;
  logic              grant_s;
  logic              capture_s;
  logic              step_s;
  logic              result_load_s;
  logic [DATA_W-1:0] load_val_s;
  logic [SW_W-1:0]   load_cnt_s;
  logic [DATA_W-1:0] result_val_s;
  logic [DATA_W-1:0] acc_shift_s;
  logic              last_step_s;

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    if (req0 && req1) begin
      arb_win_s = ~last_r;
    end else if (req1) begin
      arb_win_s = 1'b1;
    end else begin
      arb_win_s = 1'b0;
    end
    load_val_s = arb_win_s ? a1 : a0;
    load_cnt_s = arb_win_s ? sw1 : sw0;
  end

  // FSM next state and datapath controls.
  always_comb begin
    state_next_s  = state_r;
    capture_s     = 1'b0;
    step_s        = 1'b0;
    result_load_s = 1'b0;
    result_val_s  = result_r;
    grant_s       = grant_id_r;
    case (state_r)
      ST_IDLE: begin
        if (req0 || req1) begin
          capture_s = 1'b1;
          grant_s   = arb_win_s;
          if (load_cnt_s != {SW_W{1'b0}}) begin
            state_next_s = ST_SHIFT;
          end else begin
            // Zero-width shift: the operand itself is the result.
            state_next_s  = ST_DONE;
            result_load_s = 1'b1;
            result_val_s  = load_val_s;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        step_s = 1'b1;
        if (last_step_s) begin
          state_next_s  = ST_DONE;
          result_load_s = 1'b1;
          result_val_s  = acc_shift_s;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered outputs, grant owner and last-served pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_r     <= 1'b0;
      grant_id_r <= 1'b0;
      last_r     <= 1'b1;
      done0_r    <= 1'b0;
      done1_r    <= 1'b0;
      result_r   <= {DATA_W{1'b0}};
    end else begin
      busy_r  <= (state_next_s != ST_IDLE);
      done0_r <= result_load_s && (grant_s == 1'b0);
      done1_r <= result_load_s && (grant_s == 1'b1);
      if (capture_s) begin
        grant_id_r <= grant_s;
        last_r     <= grant_s;
      end else begin
        grant_id_r <= grant_id_r;
        last_r     <= last_r;
      end
      if (result_load_s) begin
        result_r <= result_val_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  shift_step_unit #(
    .DATA_W (DATA_W),
    .SW_W   (SW_W)
  ) u_step (
    .CLK       (CLK),
    .RST       (RST),
    .load      (capture_s),
    .step      (step_s),
    .load_val  (load_val_s),
    .load_cnt  (load_cnt_s),
    .acc_shift (acc_shift_s),
    .last_step (last_step_s)
  );

  assign busy     = busy_r;
  assign grant_id = grant_id_r;
  assign done0    = done0_r;
  assign done1    = done1_r;
  assign result   = result_r;

endmodule

// File: tb/tb_shift_scheduler.sv
// Scoreboard bench for shift_scheduler: stimulus pushes the expected
// requester, result and done cycle; a negedge monitor pops on every done.
module tb_shift_scheduler;

  typedef struct {
    logic       id;
    logic [7:0] res;
    int         cyc;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] a0 = 8'h00;
  logic [7:0] a1 = 8'h00;
  logic [2:0] sw0 = 3'd0;
  logic [2:0] sw1 = 3'd0;
  logic       busy;
  logic       grant_id;
  logic       done0;
  logic       done1;
  logic [7:0] result;

  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   done_seen = 0;
  exp_t sb_q[$];

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  shift_scheduler #(.DATA_W(8), .SW_W(3)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .req0     (req0),
    .a0       (a0),
    .sw0      (sw0),
    .req1     (req1),
    .a1       (a1),
    .sw1      (sw1),
    .busy     (busy),
    .grant_id (grant_id),
    .done0    (done0),
    .done1    (done1),
    .result   (result)
  );

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_op(input logic id, input logic [7:0] res, input int at);
    exp_t e;
    e.id  = id;
    e.res = res;
    e.cyc = at;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for the done pulse of one requester.
  task automatic wait_done(input logic id, input string name);
    int found;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge CLK);
      if (id ? done1 : done0) found = 1;
    end
    chk(name, found, 1);
  endtask

  // Wait (bounded) until the monitor has consumed every expectation.
  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() > 0; i++) begin
      @(negedge CLK);
      #1;
    end
    chk("sb_drained", sb_q.size(), 0);
  endtask

  // Monitor: compare every done pulse against the head of the scoreboard.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && (done0 || done1)) begin
      done_seen++;
      chk("done_exclusive", int'(done0 & done1), 0);
      chk("sb_has_entry", (sb_q.size() > 0) ? 1 : 0, 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("done_id", int'(done1), int'(e.id));
        chk("result", int'(result), int'(e.res));
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int ds;
    repeat (2) @(negedge CLK);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant", int'(grant_id), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_done1", int'(done1), 0);
    chk("rst_result", int'(result), 0);

    // Tie from reset: requester 0 wins first, then requester 1.
    a0 = 8'h01; sw0 = 3'd1; a1 = 8'h01; sw1 = 3'd7;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    c = cyc;
    expect_op(1'b0, 8'h02, c + 2);
    expect_op(1'b1, 8'h80, c + 11);
    wait_done(1'b0, "wait_tie_done0");
    req0 = 1'b0;
    wait_done(1'b1, "wait_tie_done1");
    chk("tie_grant1", int'(grant_id), 1);
    chk("tie_busy", int'(busy), 1);
    req1 = 1'b0;
    @(negedge CLK);
    chk("idle_busy", int'(busy), 0);

    // Next tie goes back to requester 0.
    a0 = 8'h10; sw0 = 3'd2; a1 = 8'h22; sw1 = 3'd1;
    req0 = 1'b1; req1 = 1'b1;
    c = cyc;
    expect_op(1'b0, 8'h40, c + 3);
    expect_op(1'b1, 8'h44, c + 6);
    wait_done(1'b0, "wait_tie2_done0");
    req0 = 1'b0;
    wait_done(1'b1, "wait_tie2_done1");
    req1 = 1'b0;
    @(negedge CLK);

    // Single requester 0, shift by 3 with MSB loss.
    a0 = 8'h81; sw0 = 3'd3; req0 = 1'b1;
    c = cyc;
    expect_op(1'b0, 8'h08, c + 4);
    @(negedge CLK);
    chk("r0_busy", int'(busy), 1);
    chk("r0_grant", int'(grant_id), 0);
    wait_done(1'b0, "wait_r0_done");
    req0 = 1'b0;
    @(negedge CLK);

    // Zero-width shift for requester 1, then result holds.
    a1 = 8'h5A; sw1 = 3'd0; req1 = 1'b1;
    c = cyc;
    expect_op(1'b1, 8'h5A, c + 1);
    wait_done(1'b1, "wait_r1_done");
    req1 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("hold_result", int'(result), 8'h5A);
    chk("hold_busy", int'(busy), 0);

    // Reset mid-SHIFT aborts without a done pulse.
    a0 = 8'hFF; sw0 = 3'd7; req0 = 1'b1;
    repeat (3) @(negedge CLK);
    ds = done_seen;
    RST = 1'b1;
    req0 = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_grant", int'(grant_id), 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("abort_no_done", done_seen, ds);
    req0 = 1'b1;
    c = cyc;
    expect_op(1'b0, 8'h80, c + 8);
    wait_done(1'b0, "wait_rereq_done");
    req0 = 1'b0;
    @(negedge CLK);

    // Operand changes and req drop after capture are ignored.
    a1 = 8'h03; sw1 = 3'd2; req1 = 1'b1;
    c = cyc;
    expect_op(1'b1, 8'h0C, c + 3);
    @(negedge CLK);
    a1 = 8'hF0; sw1 = 3'd7;
    @(negedge CLK);
    req1 = 1'b0;
    drain();
    @(negedge CLK);

    // Held request re-captures in the following IDLE cycle.
    a0 = 8'h21; sw0 = 3'd2; req0 = 1'b1;
    c = cyc;
    expect_op(1'b0, 8'h84, c + 3);
    expect_op(1'b0, 8'h84, c + 7);
    wait_done(1'b0, "wait_held_done_a");
    wait_done(1'b0, "wait_held_done_b");
    req0 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("held_result_hold", int'(result), 8'h84);
    chk("held_done0_low", int'(done0), 0);
    chk("sb_empty_end", sb_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
